// File: rtl/cpu_pkg.sv
// Shared constants and loader state encoding for the CPU memory subsystem.
package cpu_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 6;
    localparam int DEPTH    = 64;
    localparam int PROG_TOP = 32;

    // Word-count value meaning "array full" in the ADDR_W+1 bit pointer
    localparam logic [ADDR_W:0]   PTR_FULL     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PROG_TOP_ADR = ADDR_W'(PROG_TOP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } load_state_t;
endpackage

// File: rtl/load_fsm.sv
// Byte-serial program loader: assembles big-endian byte pairs into words and
// emits one array write per completed word while holding the CPU.
module load_fsm
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   load_count,
    output logic              load_err,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);
    load_state_t       state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        we      = 1'b0;
        waddr   = ptr_q[ADDR_W-1:0];
        wdata   = {hi_q, load_data};
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = HI;
                    ptr_d   = '0;
                    err_d   = 1'b0;
                end
            end
            HI: begin
                // load_last on a high byte carries no meaning and is ignored
                if (load_valid) begin
                    hi_d    = load_data;
                    state_d = LO;
                end
            end
            LO: begin
                if (load_valid) begin
                    if (ptr_q == PTR_FULL) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        we      = 1'b1;
                        ptr_d   = ptr_q + 1'b1;
                        state_d = load_last ? DONE : HI;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ptr never passes PTR_FULL, so it doubles as the saturating word count
    assign load_count = ptr_q;
    assign load_err   = err_q;
    assign load_ready = (state_q == HI) || (state_q == LO);
    assign cpu_hold   = (state_q != IDLE);
endmodule

// File: rtl/memory_unit.sv
// Shared program/data flop array with combinational fetch and data ports.
// Optional `WRITE_PROTECT_EN drops CPU writes below PROG_TOP and pulses wp_fault.
module memory_unit
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PC,
    input  logic [DATA_W-1:0] A_bus,
    input  logic [DATA_W-1:0] B_bus,
    input  logic              MM,
    input  logic              MW,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] data_out,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   load_count,
    output logic              load_err,
    output logic              wp_fault
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              ld_we;
    logic [ADDR_W-1:0] ld_waddr;
    logic [DATA_W-1:0] ld_wdata;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic              unused_a_hi;

    load_fsm u_load_fsm (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_hold   (cpu_hold),
        .load_count (load_count),
        .load_err   (load_err),
        .we         (ld_we),
        .waddr      (ld_waddr),
        .wdata      (ld_wdata)
    );

    assign cpu_addr    = MM ? PC : A_bus[ADDR_W-1:0];
    assign unused_a_hi = ^A_bus[DATA_W-1:ADDR_W];

`ifdef WRITE_PROTECT_EN
    logic wp_hit;
    logic wp_fault_q, wp_fault_d;

    assign wp_hit     = MW && !cpu_hold && (cpu_addr < PROG_TOP_ADR);
    assign cpu_we     = MW && !cpu_hold && !wp_hit;
    assign wp_fault_d = wp_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wp_fault_q <= 1'b0;
        else       wp_fault_q <= wp_fault_d;
    end
    assign wp_fault = wp_fault_q;
`else
    assign cpu_we   = MW && !cpu_hold;
    assign wp_fault = 1'b0;
`endif

    // Loader has priority; cpu_we is already gated by cpu_hold, so both
    // can never be live together, but the order keeps that explicit.
    always_comb begin
        mem_d = mem_q;
        if (ld_we)
            mem_d[ld_waddr] = ld_wdata;
        else if (cpu_we)
            mem_d[cpu_addr] = B_bus;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign instruction = mem_q[PC];
    assign data_out    = mem_q[cpu_addr];
endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: reset, loader handshake, CPU access,
// overflow and mid-load reset; protection checks follow `WRITE_PROTECT_EN.
module tb_memory_unit;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] PC;
    logic [DATA_W-1:0] A_bus, B_bus;
    logic              MM, MW;
    logic [DATA_W-1:0] instruction, data_out;
    logic              load_start, load_valid, load_last;
    logic [7:0]        load_data;
    logic              load_ready, cpu_hold, load_err, wp_fault;
    logic [ADDR_W:0]   load_count;

    int compared = 0;
    int mismatched = 0;

    memory_unit dut (
        .clk         (clk),
        .reset       (reset),
        .PC          (PC),
        .A_bus       (A_bus),
        .B_bus       (B_bus),
        .MM          (MM),
        .MW          (MW),
        .instruction (instruction),
        .data_out    (data_out),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_hold    (cpu_hold),
        .load_count  (load_count),
        .load_err    (load_err),
        .wp_fault    (wp_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_data  = b;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        logic [7:0] wb;

        reset = 1'b1; PC = 6'd5; A_bus = 16'd9; B_bus = '0; MM = 1'b0; MW = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_instr",  instruction, 16'h0000);
        check("rst_dout",   data_out,    16'h0000);
        check("rst_hold",   cpu_hold,    1'b0);
        check("rst_ready",  load_ready,  1'b0);
        check("rst_count",  load_count,  7'd0);
        check("rst_err",    load_err,    1'b0);
        check("rst_wp",     wp_fault,    1'b0);

        // Two-word load with last on a high byte, a CPU write while held,
        // a stall in LO and an ignored load_start.
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("ld_hi_ready", load_ready, 1'b1);
        check("ld_hi_hold",  cpu_hold,   1'b1);
        send_byte(8'h12, 1'b1);
        check("ld_hilast_ready", load_ready, 1'b1);
        check("ld_hilast_hold",  cpu_hold,   1'b1);
        MW = 1'b1; A_bus = 16'd3; B_bus = 16'hFFFF;
        send_byte(8'h34, 1'b0);
        MW = 1'b0;
        check("ld_count1", load_count, 7'd1);
        send_byte(8'h56, 1'b0);
        load_start = 1'b1; tick(); load_start = 1'b0;
        tick(); tick();
        check("stall_count", load_count, 7'd1);
        check("stall_ready", load_ready, 1'b1);
        send_byte(8'h78, 1'b1);
        check("done_hold",  cpu_hold,   1'b1);
        check("done_ready", load_ready, 1'b0);
        check("done_count", load_count, 7'd2);
        tick();
        check("idle_hold",  cpu_hold,   1'b0);
        check("idle_count", load_count, 7'd2);
        A_bus = 16'd0; PC = 6'd1; #1;
        check("mem0", data_out,    16'h1234);
        check("mem1", instruction, 16'h5678);
        A_bus = 16'd3; #1;
        check("mem3_held_write", data_out, 16'h0000);

        // CPU write and read back through both address sources
        MW = 1'b1; MM = 1'b0; A_bus = 16'd40; B_bus = 16'hBEEF;
        tick();
        MW = 1'b0;
        check("cpu_wr_dout", data_out, 16'hBEEF);
        check("cpu_wr_wp",   wp_fault, 1'b0);
        MM = 1'b1; PC = 6'd40; A_bus = 16'd0; #1;
        check("mm_pc_dout",  data_out,    16'hBEEF);
        check("mm_pc_instr", instruction, 16'hBEEF);
        MM = 1'b0;

        // Write to address 10: dropped under protection, accepted otherwise
        MW = 1'b1; A_bus = 16'd10; B_bus = 16'h1111;
        tick();
        MW = 1'b0;
`ifdef WRITE_PROTECT_EN
        check("wp_mem10",   data_out, 16'h0000);
        check("wp_pulse",   wp_fault, 1'b1);
        tick();
        check("wp_clear",   wp_fault, 1'b0);
`else
        check("nowp_mem10", data_out, 16'h1111);
        check("nowp_fault", wp_fault, 1'b0);
`endif

        // Overflow: 65 words, the last one must be dropped
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int w = 0; w < 65; w++) begin
            wb = 8'(w);
            send_byte(wb ^ 8'h5A, 1'b0);
            send_byte(wb, w == 64);
            if (w == 63) begin
                check("full_count", load_count, 7'd64);
                check("full_err",   load_err,   1'b0);
            end
        end
        check("ovf_err",   load_err,   1'b1);
        check("ovf_hold",  cpu_hold,   1'b1);
        check("ovf_count", load_count, 7'd64);
        tick();
        check("ovf_idle_hold", cpu_hold, 1'b0);
        check("ovf_sticky",    load_err, 1'b1);
        A_bus = 16'd0; PC = 6'd63; #1;
        check("ovf_mem0",  data_out,    16'h5A00);
        check("ovf_mem63", instruction, 16'h653F);

        // New load clears err/count; reset mid-word restores reset state
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("restart_err",   load_err,   1'b0);
        check("restart_count", load_count, 7'd0);
        send_byte(8'hAB, 1'b0);
        reset = 1'b1; #2;
        check("mrst_hold",  cpu_hold,    1'b0);
        check("mrst_ready", load_ready,  1'b0);
        check("mrst_count", load_count,  7'd0);
        check("mrst_err",   load_err,    1'b0);
        check("mrst_dout",  data_out,    16'h0000);
        check("mrst_instr", instruction, 16'h0000);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ready", load_ready, 1'b0);
        check("post_rst_hold",  cpu_hold,   1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
